dekatron_step_sequencer: RTL and testbench
==========================================

DEKATRON_STEP_SEQUENCER -- requirements
Module: dekatron_step_sequencer

Interface
REQ-001 Parameter DIGITS, default 3: number of BCD decade counters driven (1..6).
REQ-002 Parameter PULSE_CYCLES, default 4: step/clear pulse width in CLK cycles (>=1).
REQ-003 Parameter GAP_CYCLES, default 4: idle gap after each pulse, in CLK cycles (>=1).
REQ-004 CLK  input  1: system clock; all state updates on rising edge.
REQ-005 RST  input  1: reset, synchronous, active-high.
REQ-006 CMD_VALID  input  1: command offered.
REQ-007 CMD_READY  output  1: sequencer can accept a command.
REQ-008 CMD_DIR  input  1: 0 = count up, 1 = count down.
REQ-009 CMD_COUNT  input  8: number of steps, 0..255.
REQ-010 CMD_CLEAR  input  1: clear command; overrides CMD_DIR/CMD_COUNT.
REQ-011 STEP_UP  output  DIGITS: per-decade up pulse, bit i drives decade i.
REQ-012 STEP_DOWN  output  DIGITS: per-decade down pulse.
REQ-013 CNT_RSTN  output  1: active-low clear to all decade counters.
REQ-014 VALUE  output  4*DIGITS: shadow BCD value, decade 0 in bits [3:0].
REQ-015 BUSY  output  1: high whenever state is not IDLE.
REQ-016 DONE  output  1: one-cycle pulse on command completion.

Function
REQ-017 FSM states SHALL be IDLE, PULSE, GAP, CLEAR.
REQ-018 CMD_READY SHALL equal (state==IDLE); a command is accepted on an edge where CMD_VALID && CMD_READY.
REQ-019 Accepted CMD_CLEAR=1: next state CLEAR; CNT_RSTN low exactly PULSE_CYCLES cycles; VALUE set to all zero on entry; then IDLE with DONE pulse.
REQ-020 Accepted step command with CMD_COUNT=0: stay IDLE, DONE high the next cycle, no pulses, VALUE unchanged.
REQ-021 Accepted step command with CMD_COUNT=N>0: latch N and DIR; enter PULSE the following cycle.
REQ-022 Per step, decade 0 SHALL pulse; decade i>0 pulses in the same window iff all lower decades wrap (up: all lower ==9; down: all lower ==0).
REQ-023 Pulse direction selects STEP_UP or STEP_DOWN; the other vector stays 0 throughout.
REQ-024 STEP outputs high for exactly PULSE_CYCLES cycles (state PULSE), then all low for GAP_CYCLES cycles (state GAP).
REQ-025 VALUE SHALL update on entry to PULSE, BCD per decade: up 9->0 with carry, down 0->9 with borrow.
REQ-026 Full-range wrap: up from all-9 gives all-0 with every decade pulsed; down from all-0 gives all-9, every decade pulsed.
REQ-027 Remaining-step counter decrements at end of each GAP; at zero, next state IDLE and DONE pulses in the first IDLE cycle.
REQ-028 Total busy time for N steps SHALL be N*(PULSE_CYCLES+GAP_CYCLES) cycles; no pulse overlaps another.
REQ-029 CMD_VALID while BUSY SHALL be ignored (not queued); inputs sampled only at acceptance.
REQ-030 STEP_UP and STEP_DOWN SHALL never be nonzero simultaneously; CNT_RSTN never low during PULSE/GAP.

Reset
REQ-031 RST high at any edge, including mid-PULSE/GAP/CLEAR: state IDLE, STEP_UP=STEP_DOWN=0, CNT_RSTN=1, VALUE=0, BUSY=0, DONE=0, remaining count 0.
REQ-032 After RST the external decades are not cleared by this block; software SHALL issue CMD_CLEAR before the first step command.
REQ-033 First command accepted on the first edge with RST low, CMD_VALID high.

Verification
REQ-034 CLEAR, then up N=3 (defaults) -> three STEP_UP[0] pulses, 4 high/4 low each, VALUE=003, BUSY 24 cycles, one DONE.
REQ-035 VALUE=009, up N=1 -> STEP_UP=3'b011 for 4 cycles, VALUE=010.
REQ-036 VALUE=000, down N=1 -> STEP_DOWN=3'b111, VALUE=999; then up N=1 -> STEP_UP=3'b111, VALUE=000.
REQ-037 CMD_COUNT=0 -> no pulses, DONE one cycle after acceptance, CMD_READY stays high.
REQ-038 RST asserted during 2nd PULSE cycle of N=5 -> outputs idle next edge, VALUE=000, no DONE.
REQ-039 CMD_VALID held high with new command while BUSY -> ignored until DONE; accepted in the DONE cycle (state IDLE).

Source files
------------

// File: rtl/dekatron_step_sequencer_if.sv
// Command handshake and decade-drive bundle between a controller and the dekatron step sequencer.
interface dekatron_step_sequencer_if #(
    parameter int DIGITS = 3
);
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic                  CMD_DIR;
    logic [7:0]            CMD_COUNT;
    logic                  CMD_CLEAR;
    logic [DIGITS-1:0]     STEP_UP;
    logic [DIGITS-1:0]     STEP_DOWN;
    logic                  CNT_RSTN;
    logic [4*DIGITS-1:0]   VALUE;
    logic                  BUSY;
    logic                  DONE;

    modport master (
        output CMD_VALID, CMD_DIR, CMD_COUNT, CMD_CLEAR,
        input  CMD_READY, STEP_UP, STEP_DOWN, CNT_RSTN, VALUE, BUSY, DONE
    );

    modport slave (
        input  CMD_VALID, CMD_DIR, CMD_COUNT, CMD_CLEAR,
        output CMD_READY, STEP_UP, STEP_DOWN, CNT_RSTN, VALUE, BUSY, DONE
    );
endinterface

// File: rtl/dekatron_step_sequencer.sv
// Drives step/clear pulses into a chain of BCD decade counters and keeps a shadow of their value.
module dekatron_step_sequencer #(
    parameter int DIGITS       = 3,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    dekatron_step_sequencer_if.slave   bus,
    output logic [1:0]                 dbg_state_o
);
    // Handshake: a command transfers on a rising CLK edge where CMD_VALID && CMD_READY;
    // CMD_READY is high only in IDLE, and command fields are sampled only on that edge.

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_CLEAR} state_e;

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [7:0]            remain_q, remain_d;
    logic                  dir_q, dir_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [DIGITS-1:0]     mask_q, mask_d;
    logic                  done_q, done_d;
    logic [5*DIGITS-1:0]   acc_step, nxt_step;

    // Returns {pulse mask, new value}: decade i pulses iff every lower decade wrapped.
    function automatic logic [5*DIGITS-1:0] bcd_step(input logic [4*DIGITS-1:0] v, input logic down);
        logic [4*DIGITS-1:0] nv;
        logic [DIGITS-1:0]   m;
        logic                carry;
        logic [3:0]          d;
        nv    = v;
        m     = '0;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d    = v[4*i +: 4];
            m[i] = carry;
            if (carry) begin
                if (!down) begin
                    if (d == 4'd9) d = 4'd0;
                    else begin d = d + 4'd1; carry = 1'b0; end
                end else begin
                    if (d == 4'd0) d = 4'd9;
                    else begin d = d - 4'd1; carry = 1'b0; end
                end
            end
            nv[4*i +: 4] = d;
        end
        return {m, nv};
    endfunction

    assign acc_step = bcd_step(value_q, bus.CMD_DIR);
    assign nxt_step = bcd_step(value_q, dir_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            remain_q <= '0;
            dir_q    <= 1'b0;
            value_q  <= '0;
            mask_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            remain_q <= remain_d;
            dir_q    <= dir_d;
            value_q  <= value_d;
            mask_q   <= mask_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        remain_d = remain_q;
        dir_d    = dir_q;
        value_d  = value_q;
        mask_d   = mask_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.CMD_VALID) begin
                    timer_d = '0;
                    if (bus.CMD_CLEAR) begin
                        state_d = S_CLEAR;
                        value_d = '0;
                    end else if (bus.CMD_COUNT == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d           = S_PULSE;
                        remain_d          = bus.CMD_COUNT;
                        dir_d             = bus.CMD_DIR;
                        {mask_d, value_d} = acc_step;
                    end
                end
            end
            S_PULSE: begin
                if (timer_q == TW'(PULSE_CYCLES - 1)) begin
                    state_d = S_GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_GAP: begin
                if (timer_q == TW'(GAP_CYCLES - 1)) begin
                    timer_d  = '0;
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d           = S_PULSE;
                        {mask_d, value_d} = nxt_step;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CLEAR: begin
                if (timer_q == TW'(PULSE_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.CMD_READY = (state_q == S_IDLE);
        bus.BUSY      = (state_q != S_IDLE);
        bus.STEP_UP   = ((state_q == S_PULSE) && !dir_q) ? mask_q : '0;
        bus.STEP_DOWN = ((state_q == S_PULSE) &&  dir_q) ? mask_q : '0;
        bus.CNT_RSTN  = (state_q != S_CLEAR);
        bus.VALUE     = value_q;
        bus.DONE      = done_q;
        dbg_state_o   = state_q;
    end
endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Directed bench for dekatron_step_sequencer: clear, carry/borrow, zero-count, busy-ignore and mid-pulse reset.
module tb_dekatron_step_sequencer;
    logic       CLK;
    logic       RST;
    logic [1:0] dbg_state;
    int         total;
    int         bad;

    int         w_busy, w_uphi, w_dnhi, w_pulses, w_bad;
    logic [2:0] w_upor, w_dnor;

    dekatron_step_sequencer_if #(.DIGITS(3)) bus ();

    dekatron_step_sequencer #(
        .DIGITS(3), .PULSE_CYCLES(4), .GAP_CYCLES(4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one command for exactly one edge; returns at the negedge after acceptance.
    task automatic start(input logic clr, input logic dir, input logic [7:0] cnt);
        bus.CMD_VALID = 1'b1;
        bus.CMD_CLEAR = clr;
        bus.CMD_DIR   = dir;
        bus.CMD_COUNT = cnt;
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
    endtask

    // Observe from the current busy cycle until BUSY drops, bounded.
    task automatic watch();
        int  n;
        logic prev, cur;
        n = 0; prev = 1'b0;
        w_uphi = 0; w_dnhi = 0; w_pulses = 0; w_bad = 0; w_upor = '0; w_dnor = '0;
        while (bus.BUSY === 1'b1 && n < 4000) begin
            if (bus.STEP_UP != 0) w_uphi++;
            if (bus.STEP_DOWN != 0) w_dnhi++;
            cur = (bus.STEP_UP | bus.STEP_DOWN) != 0;
            if (cur && !prev) w_pulses++;
            prev = cur;
            w_upor |= bus.STEP_UP;
            w_dnor |= bus.STEP_DOWN;
            if ((bus.STEP_UP != 0 && bus.STEP_DOWN != 0) || bus.CNT_RSTN !== 1'b1) w_bad++;
            n++;
            @(negedge CLK);
        end
        w_busy = n;
        check("watch_timeout", 32'(n < 4000), 32'd1);
    endtask

    task automatic do_clear(input string tag);
        int n;
        start(1'b1, 1'b0, 8'd0);
        check({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
        check({tag, "_value"}, 32'(bus.VALUE), 32'h000);
        n = 0;
        while (bus.CNT_RSTN === 1'b0 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        check({tag, "_rstn_low_cycles"}, 32'(n), 32'd4);
        check({tag, "_done"}, 32'(bus.DONE), 32'd1);
        check({tag, "_ready"}, 32'(bus.CMD_READY), 32'd1);
        @(negedge CLK);
        check({tag, "_done_drop"}, 32'(bus.DONE), 32'd0);
    endtask

    task automatic run_steps(input string tag, input logic dir, input int cnt,
                             input logic [11:0] exp_val, input logic [2:0] exp_mask);
        start(1'b0, dir, 8'(cnt));
        watch();
        check({tag, "_busy_cycles"}, 32'(w_busy), 32'(cnt * 8));
        check({tag, "_pulses"}, 32'(w_pulses), 32'(cnt));
        check({tag, "_hi_cycles"}, 32'(dir ? w_dnhi : w_uphi), 32'(cnt * 4));
        check({tag, "_other_dir"}, 32'(dir ? w_upor : w_dnor), 32'd0);
        check({tag, "_mask"}, 32'(dir ? w_dnor : w_upor), 32'(exp_mask));
        check({tag, "_illegal"}, 32'(w_bad), 32'd0);
        check({tag, "_done"}, 32'(bus.DONE), 32'd1);
        check({tag, "_value"}, 32'(bus.VALUE), 32'(exp_val));
        @(negedge CLK);
        check({tag, "_done_drop"}, 32'(bus.DONE), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST = 1'b1;
        bus.CMD_VALID = 1'b0; bus.CMD_CLEAR = 1'b0; bus.CMD_DIR = 1'b0; bus.CMD_COUNT = 8'd0;
        repeat (2) @(negedge CLK);
        check("rst_ready", 32'(bus.CMD_READY), 32'd1);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_value", 32'(bus.VALUE), 32'h000);
        check("rst_rstn", 32'(bus.CNT_RSTN), 32'd1);
        check("rst_steps", 32'({bus.STEP_UP, bus.STEP_DOWN}), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        RST = 1'b0;

        // First edge after reset accepts the clear.
        do_clear("clr1");
        run_steps("up3", 1'b0, 3, 12'h003, 3'b001);
        run_steps("up6", 1'b0, 6, 12'h009, 3'b001);
        run_steps("carry", 1'b0, 1, 12'h010, 3'b011);
        do_clear("clr2");
        run_steps("borrow_all", 1'b1, 1, 12'h999, 3'b111);
        run_steps("carry_all", 1'b0, 1, 12'h000, 3'b111);

        // Zero-count command completes without leaving IDLE.
        start(1'b0, 1'b0, 8'd0);
        check("zero_done", 32'(bus.DONE), 32'd1);
        check("zero_ready", 32'(bus.CMD_READY), 32'd1);
        check("zero_busy", 32'(bus.BUSY), 32'd0);
        check("zero_steps", 32'({bus.STEP_UP, bus.STEP_DOWN}), 32'd0);
        check("zero_value", 32'(bus.VALUE), 32'h000);
        @(negedge CLK);
        check("zero_done_drop", 32'(bus.DONE), 32'd0);

        // A command held while busy is taken only in the DONE cycle.
        start(1'b0, 1'b0, 8'd2);
        bus.CMD_VALID = 1'b1; bus.CMD_DIR = 1'b1; bus.CMD_COUNT = 8'd1;
        watch();
        check("hold_busy_cycles", 32'(w_busy), 32'd16);
        check("hold_first_dn", 32'(w_dnor), 32'd0);
        check("hold_value1", 32'(bus.VALUE), 32'h002);
        check("hold_done", 32'(bus.DONE), 32'd1);
        check("hold_ready", 32'(bus.CMD_READY), 32'd1);
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        check("hold_accepted", 32'(bus.BUSY), 32'd1);
        check("hold_value2", 32'(bus.VALUE), 32'h001);
        check("hold_step_down", 32'(bus.STEP_DOWN), 32'b001);
        watch();
        check("hold2_busy_cycles", 32'(w_busy), 32'd8);
        check("hold2_dn_hi", 32'(w_dnhi), 32'd4);
        check("hold2_done", 32'(bus.DONE), 32'd1);
        @(negedge CLK);

        // Reset in the second PULSE cycle of a 5-step command.
        start(1'b0, 1'b0, 8'd5);
        check("mid_value", 32'(bus.VALUE), 32'h002);
        check("mid_step_up", 32'(bus.STEP_UP), 32'b001);
        @(negedge CLK);
        check("mid_state_pulse", 32'(dbg_state), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        check("mid_rst_steps", 32'({bus.STEP_UP, bus.STEP_DOWN}), 32'd0);
        check("mid_rst_value", 32'(bus.VALUE), 32'h000);
        check("mid_rst_rstn", 32'(bus.CNT_RSTN), 32'd1);
        check("mid_rst_done", 32'(bus.DONE), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("mid_post_done", 32'(bus.DONE), 32'd0);
        check("mid_post_busy", 32'(bus.BUSY), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
